// File: rtl/lidar_crc_frame_ctrl_if.sv
// Word stream in and per-frame verdict out for the CRC frame controller.
// Latency: none, wiring only.
// Backpressure: s_ready throttles the word stream; res_ready holds the verdict.
interface lidar_crc_frame_ctrl_if #(
    parameter int ERR_CNT_W = 16
);
    logic                 s_valid;
    logic                 s_ready;
    logic [31:0]          s_data;
    logic                 s_last;
    logic                 res_valid;
    logic                 res_ready;
    logic                 crc_error;
    logic                 len_error;
    logic [31:0]          calc_crc;
    logic [ERR_CNT_W-1:0] err_count;

    // Producer of words and consumer of verdicts.
    modport master (
        output s_valid, s_data, s_last, res_ready,
        input  s_ready, res_valid, crc_error, len_error, calc_crc, err_count
    );

    // The frame controller itself.
    modport slave (
        input  s_valid, s_data, s_last, res_ready,
        output s_ready, res_valid, crc_error, len_error, calc_crc, err_count
    );
endinterface

// File: rtl/lidar_crc_frame_ctrl.sv
// Streaming CRC-32 checker for fixed-length LiDAR frames, one payload byte per cycle.
// Latency: 5*FRAME_WORDS+2 cycles from first word accept to res_valid with no input gaps.
// Backpressure: s_ready drops while bytes shift and while a verdict waits for res_ready.
module lidar_crc_frame_ctrl #(
    parameter int FRAME_WORDS = 16,
    parameter int ERR_CNT_W   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  crc_enable,
    lidar_crc_frame_ctrl_if.slave bus
);
    localparam int              WC_W     = $clog2(FRAME_WORDS + 1);
    localparam logic [WC_W-1:0] LAST_WC  = WC_W'(FRAME_WORDS);
    localparam logic [31:0]     CRC_POLY = 32'hEDB88320;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_WAIT,
        ST_COMPARE,
        ST_REPORT
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic                 rdy;
    logic                 accept;
    logic                 res_hs;
    logic [31:0]          crc_reg;
    logic [31:0]          crc_nxt;
    logic [31:0]          word_reg;
    logic [WC_W-1:0]      word_cnt;
    logic [1:0]           byte_cnt;
    logic                 en_r;
    logic                 last_r;
    logic                 crc_error_r;
    logic                 len_error_r;
    logic [31:0]          calc_crc_r;
    logic [ERR_CNT_W-1:0] err_cnt_r;

    // Reflected CRC-32 over one byte, LSB first, eight shift/XOR steps.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc ^ {24'h0, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        end
        return c;
    endfunction

    // Byte byte_cnt of the held word, [7:0] first.
    assign crc_nxt = crc32_byte(crc_reg, word_reg[{byte_cnt, 3'b000} +: 8]);

    // Ready is forced low while reset is asserted so nothing is taken in the reset cycle.
    assign bus.s_ready   = rdy & ~rst;
    assign accept        = bus.s_valid & bus.s_ready;
    assign res_hs        = (state == ST_REPORT) & bus.res_ready;
    assign bus.res_valid = (state == ST_REPORT);
    assign bus.crc_error = crc_error_r;
    assign bus.len_error = len_error_r;
    assign bus.calc_crc  = calc_crc_r;
    assign bus.err_count = err_cnt_r;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Next-state decode and word-port ready.
    always_comb begin
        state_nxt = state;
        rdy       = 1'b0;
        case (state)
            ST_IDLE: begin
                rdy = 1'b1;
                if (bus.s_valid) state_nxt = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (byte_cnt == 2'd3) begin
                    // An early s_last ends the frame without waiting for a CRC word.
                    if (last_r)                    state_nxt = ST_REPORT;
                    else if (word_cnt == LAST_WC)  state_nxt = ST_COMPARE;
                    else                           state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                rdy = 1'b1;
                if (bus.s_valid) state_nxt = ST_SHIFT;
            end
            ST_COMPARE: begin
                rdy = 1'b1;
                if (bus.s_valid) state_nxt = ST_REPORT;
            end
            ST_REPORT: begin
                if (bus.res_ready) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Datapath: word capture, CRC update, verdict latch; verdict holds through REPORT.
    always_ff @(posedge clk) begin
        if (rst) begin
            crc_reg     <= '1;
            word_reg    <= '0;
            word_cnt    <= '0;
            byte_cnt    <= '0;
            en_r        <= 1'b0;
            last_r      <= 1'b0;
            crc_error_r <= 1'b0;
            len_error_r <= 1'b0;
            calc_crc_r  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        crc_reg  <= '1;
                        en_r     <= crc_enable;
                        word_reg <= bus.s_data;
                        last_r   <= bus.s_last;
                        word_cnt <= WC_W'(1);
                        byte_cnt <= 2'd0;
                    end
                end
                ST_SHIFT: begin
                    crc_reg  <= crc_nxt;
                    byte_cnt <= byte_cnt + 2'd1;
                    if (byte_cnt == 2'd3 && last_r) begin
                        calc_crc_r  <= ~crc_nxt;
                        len_error_r <= 1'b1;
                        crc_error_r <= en_r;
                    end
                end
                ST_WAIT: begin
                    if (accept) begin
                        word_reg <= bus.s_data;
                        last_r   <= bus.s_last;
                        word_cnt <= word_cnt + WC_W'(1);
                    end
                end
                ST_COMPARE: begin
                    if (accept) begin
                        calc_crc_r  <= ~crc_reg;
                        len_error_r <= ~bus.s_last;
                        crc_error_r <= en_r & ((bus.s_data != ~crc_reg) | ~bus.s_last);
                    end
                end
                default: ;
            endcase
        end
    end

    // Saturating count of failed verdicts, bumped on the REPORT handshake.
    always_ff @(posedge clk) begin
        if (rst)
            err_cnt_r <= '0;
        else if (res_hs && crc_error_r && (err_cnt_r != {ERR_CNT_W{1'b1}}))
            err_cnt_r <= err_cnt_r + ERR_CNT_W'(1);
    end
endmodule

// File: tb/tb_lidar_crc_frame_ctrl.sv
// Directed bench for lidar_crc_frame_ctrl: three instances (1-word, 2-word, 2-bit counter).
// Latency: inputs driven on the falling edge, outputs sampled on the falling edge.
// Backpressure: res_ready is held low for a stretch to exercise the REPORT hold.
module tb_lidar_crc_frame_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        crc_enable;
    logic [1:0]  sel;
    logic        drv_valid;
    logic [31:0] drv_data;
    logic        drv_last;
    logic        drv_res_ready;

    logic        mon_s_ready;
    logic        mon_res_valid;
    logic        mon_crc_error;
    logic        mon_len_error;
    logic [31:0] mon_calc_crc;
    logic [15:0] mon_err_count;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int res_cyc = 0;
    int t0 = 0;
    logic [31:0] snap_calc;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    lidar_crc_frame_ctrl_if #(.ERR_CNT_W(16)) if0 ();
    lidar_crc_frame_ctrl_if #(.ERR_CNT_W(16)) if1 ();
    lidar_crc_frame_ctrl_if #(.ERR_CNT_W(2))  if2 ();

    assign if0.s_valid = drv_valid & (sel == 2'd0);
    assign if1.s_valid = drv_valid & (sel == 2'd1);
    assign if2.s_valid = drv_valid & (sel == 2'd2);
    assign if0.s_data = drv_data;
    assign if1.s_data = drv_data;
    assign if2.s_data = drv_data;
    assign if0.s_last = drv_last;
    assign if1.s_last = drv_last;
    assign if2.s_last = drv_last;
    assign if0.res_ready = drv_res_ready;
    assign if1.res_ready = drv_res_ready;
    assign if2.res_ready = drv_res_ready;

    lidar_crc_frame_ctrl #(.FRAME_WORDS(1), .ERR_CNT_W(16)) dut0 (
        .clk(clk), .rst(rst), .crc_enable(crc_enable), .bus(if0.slave));
    lidar_crc_frame_ctrl #(.FRAME_WORDS(2), .ERR_CNT_W(16)) dut1 (
        .clk(clk), .rst(rst), .crc_enable(crc_enable), .bus(if1.slave));
    lidar_crc_frame_ctrl #(.FRAME_WORDS(2), .ERR_CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .crc_enable(crc_enable), .bus(if2.slave));

    always_comb begin
        mon_s_ready   = if0.s_ready;
        mon_res_valid = if0.res_valid;
        mon_crc_error = if0.crc_error;
        mon_len_error = if0.len_error;
        mon_calc_crc  = if0.calc_crc;
        mon_err_count = if0.err_count;
        if (sel == 2'd1) begin
            mon_s_ready   = if1.s_ready;
            mon_res_valid = if1.res_valid;
            mon_crc_error = if1.crc_error;
            mon_len_error = if1.len_error;
            mon_calc_crc  = if1.calc_crc;
            mon_err_count = if1.err_count;
        end else if (sel == 2'd2) begin
            mon_s_ready   = if2.s_ready;
            mon_res_valid = if2.res_valid;
            mon_crc_error = if2.crc_error;
            mon_len_error = if2.len_error;
            mon_calc_crc  = if2.calc_crc;
            mon_err_count = {14'b0, if2.err_count};
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present one word after 'gap' idle cycles and hold it until accepted.
    task automatic send_word(input logic [31:0] d, input logic l, input int gap);
        int n;
        for (int g = 0; g < gap; g++) @(negedge clk);
        drv_valid = 1'b1;
        drv_data  = d;
        drv_last  = l;
        n = 0;
        #1;
        while (!mon_s_ready && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("accept_rdy", {31'b0, mon_s_ready}, 32'd1);
        @(negedge clk);
        drv_valid = 1'b0;
        acc_cyc = cyc;
    endtask

    task automatic wait_res(input string tag, input logic ce, input logic le, input logic [31:0] cc);
        int n;
        n = 0;
        while (!mon_res_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        res_cyc = cyc;
        chk({tag, "_res_valid"}, {31'b0, mon_res_valid}, 32'd1);
        chk({tag, "_crc_error"}, {31'b0, mon_crc_error}, {31'b0, ce});
        chk({tag, "_len_error"}, {31'b0, mon_len_error}, {31'b0, le});
        chk({tag, "_calc_crc"}, mon_calc_crc, cc);
    endtask

    // Two-word "12345678" frame with the given CRC word and gaps.
    task automatic frame2(input logic [31:0] crcw, input logic lastw, input int gmax);
        send_word(32'h34333231, 1'b0, $urandom_range(0, gmax));
        t0 = acc_cyc;
        send_word(32'h38373635, 1'b0, $urandom_range(0, gmax));
        send_word(crcw, lastw, $urandom_range(0, gmax));
    endtask

    initial begin
        rst = 1'b1;
        crc_enable = 1'b1;
        sel = 2'd0;
        drv_valid = 1'b0;
        drv_data = '0;
        drv_last = 1'b0;
        drv_res_ready = 1'b1;

        // Reset cycle and post-reset values.
        @(negedge clk);
        chk("rst_s_ready", {31'b0, mon_s_ready}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_s_ready", {31'b0, mon_s_ready}, 32'd1);
        chk("idle_res_valid", {31'b0, mon_res_valid}, 32'd0);
        chk("idle_crc_error", {31'b0, mon_crc_error}, 32'd0);
        chk("idle_len_error", {31'b0, mon_len_error}, 32'd0);
        chk("idle_calc_crc", mon_calc_crc, 32'd0);
        chk("idle_err_count", {16'b0, mon_err_count}, 32'd0);

        // One-word frame "1234": verdict in cycle 7 counting the accept cycle as 1.
        send_word(32'h34333231, 1'b0, 0);
        t0 = acc_cyc;
        send_word(32'h9BE3E0A3, 1'b1, 0);
        wait_res("fw1", 1'b0, 1'b0, 32'h9BE3E0A3);
        chk("fw1_latency", res_cyc - t0 + 2, 32'd7);
        @(negedge clk);
        chk("fw1_after_rdy", {31'b0, mon_s_ready}, 32'd1);
        chk("fw1_after_vld", {31'b0, mon_res_valid}, 32'd0);

        // Two-word frame "12345678", matching CRC.
        sel = 2'd1;
        @(negedge clk);
        frame2(32'h9AE0DAAF, 1'b1, 0);
        wait_res("fw2_pass", 1'b0, 1'b0, 32'h9AE0DAAF);
        chk("fw2_latency", res_cyc - t0 + 2, 32'd12);
        @(negedge clk);
        chk("fw2_pass_cnt", {16'b0, mon_err_count}, 32'd0);

        // Mismatching CRC word.
        frame2(32'h9AE0DAAE, 1'b1, 0);
        wait_res("fw2_bad", 1'b1, 1'b0, 32'h9AE0DAAF);
        @(negedge clk);
        chk("fw2_bad_cnt", {16'b0, mon_err_count}, 32'd1);

        // Same mismatch with checking disabled.
        crc_enable = 1'b0;
        frame2(32'h9AE0DAAE, 1'b1, 0);
        wait_res("dis_bad", 1'b0, 1'b0, 32'h9AE0DAAF);
        @(negedge clk);
        chk("dis_bad_cnt", {16'b0, mon_err_count}, 32'd1);

        // Enable dropped after the first word: the latched enable still applies.
        crc_enable = 1'b1;
        send_word(32'h34333231, 1'b0, 0);
        crc_enable = 1'b0;
        send_word(32'h38373635, 1'b0, 0);
        send_word(32'h9AE0DAAE, 1'b1, 0);
        wait_res("en_mid", 1'b1, 1'b0, 32'h9AE0DAAF);
        @(negedge clk);
        chk("en_mid_cnt", {16'b0, mon_err_count}, 32'd2);
        crc_enable = 1'b1;

        // Early s_last on payload word 0 ends the frame after its shift.
        send_word(32'h34333231, 1'b1, 0);
        wait_res("early_last", 1'b1, 1'b1, 32'h9BE3E0A3);
        @(negedge clk);
        chk("early_last_cnt", {16'b0, mon_err_count}, 32'd3);
        frame2(32'h9AE0DAAF, 1'b1, 0);
        wait_res("recover", 1'b0, 1'b0, 32'h9AE0DAAF);
        @(negedge clk);

        // Missing s_last on the CRC word, checking on, then off.
        frame2(32'h9AE0DAAF, 1'b0, 0);
        wait_res("no_last", 1'b1, 1'b1, 32'h9AE0DAAF);
        @(negedge clk);
        chk("no_last_cnt", {16'b0, mon_err_count}, 32'd4);
        crc_enable = 1'b0;
        frame2(32'h9AE0DAAF, 1'b0, 0);
        wait_res("no_last_dis", 1'b0, 1'b1, 32'h9AE0DAAF);
        @(negedge clk);
        crc_enable = 1'b1;

        // Verdict held for 10 cycles while junk words are offered.
        drv_res_ready = 1'b0;
        frame2(32'h9AE0DAAF, 1'b1, 0);
        wait_res("bp", 1'b0, 1'b0, 32'h9AE0DAAF);
        snap_calc = 32'h9AE0DAAF;
        for (int k = 0; k < 10; k++) begin
            drv_valid = 1'b1;
            drv_data  = 32'hDEADBEEF;
            drv_last  = 1'b1;
            #1;
            chk("bp_s_ready", {31'b0, mon_s_ready}, 32'd0);
            chk("bp_res_valid", {31'b0, mon_res_valid}, 32'd1);
            chk("bp_calc_crc", mon_calc_crc, snap_calc);
            chk("bp_crc_error", {31'b0, mon_crc_error}, 32'd0);
            @(negedge clk);
        end
        drv_valid = 1'b0;
        drv_res_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_vld", {31'b0, mon_res_valid}, 32'd0);
        chk("bp_release_rdy", {31'b0, mon_s_ready}, 32'd1);
        chk("bp_cnt", {16'b0, mon_err_count}, 32'd4);

        // Randomised input gaps give the same verdicts.
        frame2(32'h9AE0DAAF, 1'b1, 4);
        wait_res("gap_pass", 1'b0, 1'b0, 32'h9AE0DAAF);
        @(negedge clk);
        frame2(32'h9AE0DAAE, 1'b1, 4);
        wait_res("gap_bad", 1'b1, 1'b0, 32'h9AE0DAAF);
        @(negedge clk);
        chk("gap_cnt", {16'b0, mon_err_count}, 32'd5);

        // Reset while shifting the first word.
        send_word(32'h34333231, 1'b0, 0);
        rst = 1'b1;
        #1;
        chk("rst_mid_rdy", {31'b0, mon_s_ready}, 32'd0);
        @(negedge clk);
        chk("rst_mid_vld", {31'b0, mon_res_valid}, 32'd0);
        chk("rst_mid_crc_error", {31'b0, mon_crc_error}, 32'd0);
        chk("rst_mid_len_error", {31'b0, mon_len_error}, 32'd0);
        chk("rst_mid_calc", mon_calc_crc, 32'd0);
        chk("rst_mid_cnt", {16'b0, mon_err_count}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_idle_rdy", {31'b0, mon_s_ready}, 32'd1);
        frame2(32'h9AE0DAAF, 1'b1, 0);
        wait_res("post_rst", 1'b0, 1'b0, 32'h9AE0DAAF);
        @(negedge clk);

        // Two-bit counter saturates at 3.
        sel = 2'd2;
        @(negedge clk);
        for (int k = 1; k <= 5; k++) begin
            frame2(32'h9AE0DAAE, 1'b1, 0);
            wait_res("sat", 1'b1, 1'b0, 32'h9AE0DAAF);
            @(negedge clk);
            chk("sat_cnt", {16'b0, mon_err_count}, (k < 3) ? k : 3);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no end of run, expected end before time limit");
        $fatal(1, "watchdog");
    end
endmodule
